seq_result_collector: RTL and testbench

- Sits directly downstream of sequence_gen.
- Watches sequence_gen's completion flags (done/error/overflow) and captures each result word plus a status code into a small FIFO.
- Presents captured results to a consumer over a valid/ready interface.
- Issues the clear pulse that sequence_gen needs after an error or overflow, so the upstream driver no longer has to time clear itself.

---
 rtl/seq_gen_pkg.sv | 11 +
 rtl/seq_sync_fifo.sv | 37 +++
 rtl/seq_result_collector.sv | 106 ++++++++++
 tb/tb_seq_result_collector.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: constants and types shared by sequence_gen and its result collector
package seq_gen_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int FIB_ORDER  = 16;
  typedef logic [1:0] status_t;
  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_OVF     = 2'b01;
  localparam status_t ST_ERR     = 2'b10;
  localparam status_t ST_ERR_OVF = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_CLEAR, S_DRAIN} coll_state_t;
endpackage

// File: rtl/seq_sync_fifo.sv
// seq_sync_fifo: synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop
module seq_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/seq_result_collector.sv
// seq_result_collector: captures sequence_gen results into a FIFO and issues seq_clear after faults.
// Define SEQ_RESULT_TAG_EN to add a per-entry event sequence number on res_tag.
module seq_result_collector
  import seq_gen_pkg::*;
#(
  parameter int DATA_WIDTH   = seq_gen_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  done,
  input  logic                  error,
  input  logic                  overflow,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  seq_clear,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [1:0]            res_status,
  output logic                  fifo_full,
  output logic [CNT_WIDTH-1:0]  ok_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
`ifdef SEQ_RESULT_TAG_EN
  output logic [CNT_WIDTH-1:0]  res_tag,
`endif
  output logic [CNT_WIDTH-1:0]  drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLEAR_CYCLES) + 1;
`ifdef SEQ_RESULT_TAG_EN
  localparam int FW = DATA_WIDTH + 2 + CNT_WIDTH;
  logic [CNT_WIDTH-1:0] tag_cnt;
`else
  localparam int FW = DATA_WIDTH + 2;
`endif
  coll_state_t state, state_n;
  status_t st;
  logic any, any_q, push, pop, full, empty, acc, drop;
  logic [CW-1:0] clr_cnt;
  logic [AW:0] count;
  logic [FW-1:0] din, dout;
  assign any       = done | error | overflow;
  assign st        = {error, overflow};
  assign push      = state == S_CAPTURE;
  assign pop       = res_valid & res_ready;
  assign acc       = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign res_valid = ~empty;
  assign fifo_full = count[AW];
`ifdef SEQ_RESULT_TAG_EN
  assign din = {tag_cnt, st, data_out};
  assign {res_tag, res_status, res_data} = dout;
`else
  assign din = {st, data_out};
  assign {res_status, res_data} = dout;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    state_n = (any & ~any_q) ? S_SETTLE : S_IDLE;
      S_SETTLE:  state_n = S_CAPTURE;
      S_CAPTURE: state_n = (st != ST_OK) ? S_CLEAR : S_DRAIN;
      S_CLEAR:   state_n = (clr_cnt == '0) ? S_DRAIN : S_CLEAR;
      S_DRAIN:   state_n = any ? S_DRAIN : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  // seq_clear is registered from the next state so it is a clean flop output
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= S_IDLE;
      any_q     <= 1'b0;
      seq_clear <= 1'b0;
      clr_cnt   <= '0;
      ok_cnt    <= '0;
      fault_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_n;
      any_q     <= any;
      seq_clear <= state_n == S_CLEAR;
      clr_cnt   <= push ? CW'(CLEAR_CYCLES - 1) :
                   (state == S_CLEAR && clr_cnt != '0) ? clr_cnt - 1'b1 : clr_cnt;
      ok_cnt    <= ok_cnt + CNT_WIDTH'(acc && st == ST_OK && ~&ok_cnt);
      fault_cnt <= fault_cnt + CNT_WIDTH'(acc && st != ST_OK && ~&fault_cnt);
      drop_cnt  <= drop_cnt + CNT_WIDTH'(drop && ~&drop_cnt);
    end
`ifdef SEQ_RESULT_TAG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tag_cnt <= '0;
    else tag_cnt <= tag_cnt + CNT_WIDTH'(push);
`endif
  seq_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .dout    (dout),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
endmodule

// File: tb/tb_seq_result_collector.sv
// tb_seq_result_collector: directed self-checking bench for seq_result_collector
module tb_seq_result_collector;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic done = 1'b0, error = 1'b0, overflow = 1'b0, res_ready = 1'b0;
  logic [63:0] data_out = '0;
  logic seq_clear, res_valid, fifo_full;
  logic [63:0] res_data;
  logic [1:0] res_status;
  logic [15:0] ok_cnt, fault_cnt, drop_cnt;
`ifdef SEQ_RESULT_TAG_EN
  logic [15:0] res_tag;
`endif
  int vec = 0, fails = 0;

  always #5 clk = ~clk;

  seq_result_collector dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .error      (error),
    .overflow   (overflow),
    .data_out   (data_out),
    .seq_clear  (seq_clear),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_status (res_status),
    .fifo_full  (fifo_full),
    .ok_cnt     (ok_cnt),
    .fault_cnt  (fault_cnt),
`ifdef SEQ_RESULT_TAG_EN
    .res_tag    (res_tag),
`endif
    .drop_cnt   (drop_cnt)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_done(input logic [63:0] d);
    done = 1'b1;
    data_out = d;
    tick();
    done = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(3);
    chk("rst_valid", res_valid, 0);
    chk("rst_clear", seq_clear, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_data", res_data, 0);
    chk("rst_status", res_status, 0);
    chk("rst_cnts", {ok_cnt, fault_cnt, drop_cnt}, 0);
    reset_n = 1'b1;
    tick(2);
    // normal result
    res_ready = 1'b1;
    done = 1'b1;
    data_out = 64'd987;
    tick();
    done = 1'b0;
    chk("n_valid1", res_valid, 0);
    tick();
    chk("n_valid2", res_valid, 0);
    chk("n_clear2", seq_clear, 0);
    tick();
    chk("n_valid3", res_valid, 1);
    chk("n_data", res_data, 987);
    chk("n_status", res_status, 2'b00);
    chk("n_ok", ok_cnt, 1);
    chk("n_clear3", seq_clear, 0);
    tick();
    chk("n_popped", res_valid, 0);
    chk("n_clear4", seq_clear, 0);
    tick(2);
    // overflow with late data
    res_ready = 1'b0;
    overflow = 1'b1;
    data_out = 64'd5;
    tick();
    data_out = '1;
    tick(2);
    chk("o_valid", res_valid, 1);
    chk("o_data", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("o_status", res_status, 2'b01);
    chk("o_clear1", seq_clear, 1);
    chk("o_fault", fault_cnt, 1);
    tick();
    chk("o_clear2", seq_clear, 1);
    tick();
    chk("o_clear3", seq_clear, 0);
    overflow = 1'b0;
    res_ready = 1'b1;
    tick(3);
    chk("o_drained", res_valid, 0);
    // held flag then a fresh pulse
    res_ready = 1'b0;
    done = 1'b1;
    data_out = 64'd100;
    tick(20);
    done = 1'b0;
    tick(2);
    chk("h_ok1", ok_cnt, 2);
    pulse_done(64'd200);
    chk("h_ok2", ok_cnt, 3);
    chk("h_head1", res_data, 100);
    res_ready = 1'b1;
    tick();
    chk("h_head2", res_data, 200);
    tick();
    chk("h_empty", res_valid, 0);
    res_ready = 1'b0;
    // fill past capacity
    for (int i = 1; i <= 9; i++) pulse_done(64'(i));
    chk("f_full", fifo_full, 1);
    chk("f_drop", drop_cnt, 1);
    chk("f_ok", ok_cnt, 11);
    res_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("f_pop%0d", i), {63'(res_valid), res_data}, {63'(1), 64'(i)});
      tick();
    end
    chk("f_empty", res_valid, 0);
    chk("f_notfull", fifo_full, 0);
    res_ready = 1'b0;
    // push and pop in the same cycle while full
    for (int i = 11; i <= 18; i++) pulse_done(64'(i));
    chk("s_full", fifo_full, 1);
    done = 1'b1;
    data_out = 64'd19;
    tick();
    done = 1'b0;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("s_still_full", fifo_full, 1);
    chk("s_drop", drop_cnt, 1);
    chk("s_ok", ok_cnt, 20);
    chk("s_head", res_data, 12);
    tick(2);
    res_ready = 1'b1;
    for (int i = 12; i <= 19; i++) begin
      chk($sformatf("s_pop%0d", i), res_data, 64'(i));
      tick();
    end
    chk("s_empty", res_valid, 0);
    // reset during the clear pulse
    res_ready = 1'b0;
    error = 1'b1;
    data_out = 64'd7;
    tick(3);
    chk("r_clear", seq_clear, 1);
    chk("r_valid", res_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("r_clear0", seq_clear, 0);
    chk("r_valid0", res_valid, 0);
    chk("r_cnts0", {ok_cnt, fault_cnt, drop_cnt}, 0);
    error = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(2);
    done = 1'b1;
    data_out = 64'd3;
    tick();
    done = 1'b0;
    tick(2);
    chk("r_next_data", res_data, 3);
    chk("r_next_ok", ok_cnt, 1);
`ifdef SEQ_RESULT_TAG_EN
    chk("r_tag0", res_tag, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
